// File: rtl/rx_lane_unstriper.sv
// rtl/rx_lane_unstriper.sv - 4-lane serial receiver: COM symbol lock and byte un-striping
module rx_lane_unstriper #(
  parameter logic [7:0] COM_SYM = 8'hBC,
  parameter int         NLANES  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enb,
  input  logic       L0,
  input  logic       L1,
  input  logic       L2,
  input  logic       L3,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       k_out,
  output logic       locked,
  output logic       align_err
);

  localparam logic HUNT   = 1'b0;
  localparam logic LOCKED = 1'b1;
  // Sequencer emits on even steps 0,2,4,6; the last emit retires it.
  localparam logic [2:0] SEQ_LAST = 3'(2 * (NLANES - 1));

  logic       state;
  logic [2:0] bit_cnt;
  logic [7:0] sr   [4];
  logic [7:0] ns   [4];
  logic [7:0] hold [4];
  logic [3:0] khold;
  logic [3:0] match;
  logic       all_match;
  logic       partial;
  logic       seq_act;
  logic [2:0] seq_cnt;

  always_comb begin
    ns[0] = {sr[0][6:0], L0};
    ns[1] = {sr[1][6:0], L1};
    ns[2] = {sr[2][6:0], L2};
    ns[3] = {sr[3][6:0], L3};
    for (int i = 0; i < 4; i++) begin
      match[i] = (ns[i] == COM_SYM);
    end
    all_match = &match;
    partial   = |match && !all_match;
  end

  assign locked = (state == LOCKED);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= HUNT;
      bit_cnt   <= 3'd0;
      khold     <= 4'd0;
      seq_act   <= 1'b0;
      seq_cnt   <= 3'd0;
      data_out  <= 8'd0;
      valid_out <= 1'b0;
      k_out     <= 1'b0;
      align_err <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        sr[i]   <= 8'd0;
        hold[i] <= 8'd0;
      end
    end else if (!enb) begin
      valid_out <= 1'b0;
      align_err <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      align_err <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        sr[i] <= ns[i];
      end

      // The previous group keeps draining even after a lock loss.
      if (seq_act) begin
        if (!seq_cnt[0]) begin
          data_out  <= hold[seq_cnt[2:1]];
          k_out     <= khold[seq_cnt[2:1]];
          valid_out <= 1'b1;
        end
        if (seq_cnt == SEQ_LAST) begin
          seq_act <= 1'b0;
        end
        seq_cnt <= seq_cnt + 3'd1;
      end

      if (state == HUNT) begin
        if (all_match) begin
          state   <= LOCKED;
          bit_cnt <= 3'd0;
        end else if (partial) begin
          align_err <= 1'b1;
        end
      end else begin
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          if (partial) begin
            align_err <= 1'b1;
            state     <= HUNT;
            bit_cnt   <= 3'd0;
          end else begin
            for (int i = 0; i < 4; i++) begin
              hold[i] <= ns[i];
            end
            khold   <= match;
            seq_act <= 1'b1;
            seq_cnt <= 3'd0;
          end
        end
      end
    end
  end

endmodule

// File: doc/rx_lane_unstriper.md
Name: rx_lane_unstriper

Overview:
- Receive-side partner of the 4-lane transmitter; consumes the serial lanes L0..L3 it produces.
- Per lane: deserializes the bit stream MSB-first into bytes.
- Achieves symbol lock on a COM symbol that appears on all four lanes together.
- Un-stripes each aligned 4-byte group (lane0 first) into one byte stream with valid and K-flag, for the receive datapath.

Parameters:
COM_SYM, 8'hBC, comma/alignment K-symbol value
NLANES, 4, lane count (fixed at 4; documents the stripe width only)

Ports:
clk  input  1  single system clock; all logic on posedge clk
reset  input  1  synchronous, active-high reset
enb  input  1  global enable; low = full freeze
L0  input  1  serial lane 0, one bit per enabled clk, MSB first
L1  input  1  serial lane 1
L2  input  1  serial lane 2
L3  input  1  serial lane 3
data_out  output  8  un-striped byte
valid_out  output  1  data_out/k_out valid this cycle (1-cycle pulse per byte)
k_out  output  1  data_out equals COM_SYM
locked  output  1  symbol lock achieved
align_err  output  1  1-cycle pulse on partial-COM detection

Behaviour:
- Reset, sampled at posedge while reset=1:
  - shift regs, hold regs, bit counter and sequencer all cleared.
  - state=HUNT.
  - data_out=0, valid_out=0, k_out=0, locked=0, align_err=0.
  - Reset has priority over enb.
- enb=0: shift regs, counters, state and sequencer all hold; valid_out and align_err forced 0; data_out, k_out, locked hold.
- Shift: every enabled edge, sr_i <= {sr_i[6:0], Li}. "Match_i" means the post-shift value equals COM_SYM.
- State HUNT:
  - All four match -> state LOCKED, locked=1 from the next cycle, bit_cnt=0.
  - The locking COM group is not output.
  - 1 to 3 lanes match -> align_err pulses the next cycle; state stays HUNT.
  - No lanes match -> no action.
- State LOCKED:
  - bit_cnt increments 0..7 each enabled edge and wraps 7->0.
  - The edge where bit_cnt==7 is the boundary; it samples the 8th bit of the group.
  - At the boundary with all four or no lanes matching: capture post-shift bytes into hold0..hold3 (lane0..lane3); k flag per byte = (byte==COM_SYM); start the sequencer.
  - At the boundary with 1 to 3 lanes matching: discard the group (no output), align_err pulse, state=HUNT, locked=0 next cycle. Any in-flight sequence from the previous group still completes.
  - COM patterns between boundaries are ignored while LOCKED.
- Output sequencer:
  - Capture edge = cycle C. hold_j is presented with valid_out=1 in the cycle after edge C+1+2j, for j=0..3.
  - valid_out is low in the alternate cycles.
  - The last byte sits at C+7 and the next capture at C+8, so there is no overlap and throughput is 4 bytes per 8 clks.
  - data_out and k_out hold their last value while valid_out=0.
- Latency: the lane0 byte appears 1 clk after its last bit is sampled; the lane3 byte appears 7 clks after.
- Error cases emit no bytes; there is no buffering beyond one group.
- A reset asserted mid-sequence aborts it: valid_out=0 from the next cycle.

Test Plan:
- Reset held 2 cycles, lanes toggling -> all outputs 0, locked=0, no valid_out.
- COM (BC) on all lanes simultaneously, then lanes 0..3 = 01,02,03,04 -> locked=1 one cycle after the COM boundary; data_out 01,02,03,04 with valid_out in alternating cycles, the first 1 clk after the last bit; k_out=0.
- Locked, then a group of BC on all lanes -> four outputs BC with k_out=1; locked stays 1.
- HUNT with BC on lanes 0,1 only, lanes 2,3 = 00 -> align_err single pulse, locked=0, no valid_out. Then BC on all lanes -> lock.
- Locked, boundary with lane2=BC and others 55 -> align_err pulse, locked=0, that group not output. Next all-lane BC relocks and the following data group outputs normally.
- enb=0 for 3 cycles mid-byte -> output sequence identical in value, shifted 3 cycles later, no spurious valid_out. Reset pulse mid-sequence -> valid_out=0 and locked=0 from the next cycle.
